// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer_if
//  Description : Request / status bundle between a reset sequencer and the
//                block that requests sequences and watches the domain resets.
//  Revision    : 1.0  initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int NRST = 4
);
    logic            req;
    logic [NRST-1:0] assert_out;
    logic            busy;
    logic            done;

    // Requester side: raises req, observes domain resets and status.
    modport master (
        output req,
        input  assert_out,
        input  busy,
        input  done
    );

    // Sequencer side: samples req, drives domain resets and status.
    modport slave (
        input  req,
        output assert_out,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Asserts NRST reset domains together, holds them HOLD cycles,
//                then releases them one at a time GAP cycles apart. Runs on
//                leaving its own reset and on every req; req mid-sequence
//                restarts. Reports busy and pulses done on completion.
//                Optional macro RESET_SEQ_REVERSE_EN: release from the highest
//                index domain down to domain 0 instead of from domain 0 up.
//  Revision    : 1.0  initial release
// ============================================================================
module reset_sequencer #(
    parameter int NRST = 4,     // 1..16
    parameter int HOLD = 16,    // 1..255
    parameter int GAP  = 4      // 1..255
) (
    input  logic               clk,
    input  logic               rst_n,
    reset_sequencer_if.slave   bus
);

    localparam int                c_iw        = $clog2(NRST) + 1;
    localparam logic [1:0]        c_idle      = 2'd0;
    localparam logic [1:0]        c_hold      = 2'd1;
    localparam logic [1:0]        c_release   = 2'd2;
    localparam logic [7:0]        c_hold_init = 8'(HOLD - 1);
    localparam logic [7:0]        c_gap_init  = 8'(GAP - 1);
    localparam logic [c_iw-1:0]   c_last      = c_iw'(NRST - 1);
    localparam logic [NRST-1:0]   c_all_ones  = {NRST{1'b1}};

    logic [1:0]       r_state;
    logic [7:0]       r_cnt;
    logic [c_iw-1:0]  r_idx;
    logic [NRST-1:0]  r_assert;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [c_iw-1:0]  w_idx_nxt;
    logic [NRST-1:0]  w_assert_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic             w_active;
    logic             w_release;
    logic             w_finish;
    logic [c_iw-1:0]  w_order;

    // A release happens whenever the counter expires in HOLD or RELEASE and
    // no restart is pending. idx is 0 throughout HOLD, so the same "idx is
    // the last domain" test covers both the NRST=1 case and the final release.
    assign w_active  = (r_state == c_hold) || (r_state == c_release);
    assign w_release = w_active && !bus.req && (r_cnt == 8'd0);
    assign w_finish  = w_release && (r_idx == c_last);

`ifdef RESET_SEQ_REVERSE_EN
    assign w_order = c_last - r_idx;
`else
    assign w_order = r_idx;
`endif

    // State register plus registered outputs, reset into the power-on sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_hold;
            r_cnt    <= c_hold_init;
            r_idx    <= '0;
            r_assert <= c_all_ones;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_assert <= w_assert_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next state, counter and domain index; req restarts from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (bus.req) begin
            w_state_nxt = c_hold;
            w_cnt_nxt   = c_hold_init;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_idle: begin
                    w_state_nxt = c_idle;
                end
                c_hold, c_release: begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end else if (w_finish) begin
                        w_state_nxt = c_idle;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = c_release;
                        w_idx_nxt   = r_idx + c_iw'(1);
                        w_cnt_nxt   = c_gap_init;
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = 8'd0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs; done is a single-cycle pulse.
    always_comb begin
        w_assert_nxt = r_assert;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        if (bus.req) begin
            w_assert_nxt = c_all_ones;
            w_busy_nxt   = 1'b1;
        end else if (!w_active) begin
            w_assert_nxt = '0;
            w_busy_nxt   = 1'b0;
        end else if (w_release) begin
            for (int i = 0; i < NRST; i++) begin
                if (c_iw'(i) == w_order) begin
                    w_assert_nxt[i] = 1'b0;
                end
            end
            if (w_finish) begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
        end
    end

    assign bus.assert_out = r_assert;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Randomized self-checking bench for reset_sequencer. The
//                reference model tracks only the edge on which the current
//                sequence started and derives every output from elapsed time.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NRST = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int LAST_REL = HOLD + (NRST - 1) * GAP;

    logic clk;
    logic rst_n;

    reset_sequencer_if #(.NRST(NRST)) bus ();

    reset_sequencer #(
        .NRST (NRST),
        .HOLD (HOLD),
        .GAP  (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    int              edge_no   = 0;
    int              start_edge = 0;
    bit              seq_active = 1'b0;
    logic [NRST-1:0] exp_assert = '0;
    logic            exp_busy   = 1'b0;
    logic            exp_done   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    function automatic int order(input int k);
`ifdef RESET_SEQ_REVERSE_EN
        return NRST - 1 - k;
`else
        return k;
`endif
    endfunction

    // Domain order(i) is released HOLD + i*GAP edges after the start edge;
    // the sequence ends at the last release unless restarted first.
    task automatic model_edge(input logic rst_v, input logic req_v);
        int el;
        edge_no++;
        exp_done = 1'b0;
        if (!rst_v || req_v) begin
            start_edge = edge_no;
            seq_active = 1'b1;
        end
        if (seq_active) begin
            el = edge_no - start_edge;
            for (int i = 0; i < NRST; i++)
                exp_assert[order(i)] = (el < HOLD + i * GAP);
            if (el == LAST_REL) begin
                seq_active = 1'b0;
                exp_done   = 1'b1;
            end
            exp_busy = seq_active;
        end else begin
            exp_assert = '0;
            exp_busy   = 1'b0;
        end
    endtask

    // One clock: drive inputs at the falling edge, model the rising edge,
    // compare shortly after it.
    task automatic step(input logic rst_v, input logic req_v);
        @(negedge clk);
        rst_n   = rst_v;
        bus.req = req_v;
        @(posedge clk);
        model_edge(rst_v, req_v);
        #1;
        check("assert_out", 32'(bus.assert_out), 32'(exp_assert));
        check("busy",       32'(bus.busy),       32'(exp_busy));
        check("done",       32'(bus.done),       32'(exp_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 1'b0;

        // Power-on: three reset edges, then a full sequence without req.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        idle(40);

        // Plain request from idle.
        step(1'b1, 1'b1);
        idle(40);

        // Abort mid-release.
        step(1'b1, 1'b1);
        idle(20);
        step(1'b1, 1'b1);
        idle(40);

        // Request exactly on the completion edge: restart wins.
        step(1'b1, 1'b1);
        idle(LAST_REL - 1);
        step(1'b1, 1'b1);
        idle(40);

        // Held-high request keeps domains asserted.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        idle(40);

        // Mid-sequence reset, held a few cycles with req also toggling.
        step(1'b1, 1'b1);
        idle(17);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        idle(40);

        // Randomized traffic: sparse requests, rare resets, random gaps.
        for (int i = 0; i < 3000; i++) begin
            logic r_v;
            logic q_v;
            r_v = ($urandom_range(0, 199) != 0);
            q_v = ($urandom_range(0, 29) == 0);
            step(r_v, q_v);
        end
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
